// File: rtl/demux6output_if.sv
// Handshake bundle for the six-way result distributor: one producer-side
// valid/ready channel carrying a word plus destination index, and a shared
// data bus with per-port valid/ready towards the six sinks.
interface demux6output_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic [5:0]       out_valid;
  logic [5:0]       out_ready;
  logic             busy;
  logic             overflow_sel;

  // Environment side: drives words in, supplies sink readiness.
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy, overflow_sel
  );

  // Distributor side.
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy, overflow_sel
  );
endinterface

// File: rtl/demux6output.sv
// Six-way result distributor. Words enter through a small FIFO together with
// a normalised destination port (0..5) and leave in strict acceptance order
// on a shared data bus, with a one-hot valid marking the addressed sink.
// A stalled sink blocks every later word (head-of-line blocking is intended).
module demux6output #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  demux6output_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] dataMem [DEPTH];
  logic [2:0]       portMem [DEPTH];

  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          empty;
  logic          inReady;
  logic          push;
  logic          pop;
  logic [2:0]    headPort;
  logic [2:0]    selNorm;

  // Handshake decode: ready depends only on the registered count, so there
  // is no combinational path from any sink ready back to the producer.
  always_comb begin
    empty    = (count_q == '0);
    inReady  = (count_q < CW'(DEPTH));
    push     = bus.in_valid && inReady;
    headPort = portMem[rdPtr_q];
    pop      = !empty && bus.out_ready[headPort];
    selNorm  = (bus.in_sel > 3'd5) ? 3'd5 : bus.in_sel;
  end

  // Output presentation: data is forced to zero and no port is addressed
  // while the FIFO is empty, so a freshly reset block shows a clean bus.
  always_comb begin
    bus.in_ready     = inReady;
    bus.busy         = !empty;
    bus.overflow_sel = overflow_q;
    bus.out_data     = '0;
    bus.out_valid    = '0;
    if (!empty) begin
      bus.out_data  = dataMem[rdPtr_q];
      bus.out_valid = 6'b000001 << headPort;
    end
  end

  // Next-state for pointers, occupancy and the out-of-range select flag;
  // pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    count_d    = count_q;
    overflow_d = push && (bus.in_sel[2:1] == 2'b11);
    if (push) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards every buffered word at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage write: the port index is normalised on entry so the read side
  // only ever sees 0..5. Contents are never cleared; count guards them.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      dataMem[wrPtr_q] <= bus.in_data;
      portMem[wrPtr_q] <= selNorm;
    end
  end

endmodule

// File: tb/tb_demux6output.sv
// Self-checking bench for the six-way distributor. A queue models the FIFO:
// words are pushed when the model says the block is ready, and every cycle
// the DUT outputs are compared against the queue head before the edge.
module tb_demux6output;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [2:0]       port;
  } entry_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic expOvf;
  entry_t sb[$];

  demux6output_if #(.WIDTH(WIDTH)) bus ();

  demux6output #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Single comparison point with failure accounting.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare outputs against the model, predict this edge's
  // push/pop, advance the clock and update the model.
  task automatic applyStimulus();
    logic   accept;
    logic   popNow;
    entry_t e;
    accept = 1'b0;
    popNow = 1'b0;
    e.data = bus.in_data;
    e.port = (bus.in_sel > 3'd5) ? 3'd5 : bus.in_sel;
    if (!rst) begin
      checkOutput("in_ready", {31'd0, bus.in_ready}, {31'd0, sb.size() < DEPTH});
      checkOutput("busy", {31'd0, bus.busy}, {31'd0, sb.size() != 0});
      checkOutput("overflow_sel", {31'd0, bus.overflow_sel}, {31'd0, expOvf});
      if (sb.size() == 0) begin
        checkOutput("out_valid_idle", {26'd0, bus.out_valid}, 32'd0);
        checkOutput("out_data_idle", {16'd0, bus.out_data}, 32'd0);
      end else begin
        checkOutput("out_valid", {26'd0, bus.out_valid}, {26'd0, 6'b000001 << sb[0].port});
        checkOutput("out_data", {16'd0, bus.out_data}, {16'd0, sb[0].data});
        popNow = bus.out_ready[sb[0].port];
      end
      accept = bus.in_valid && (sb.size() < DEPTH);
    end
    @(posedge clk);
    if (rst) begin
      sb.delete();
      expOvf = 1'b0;
    end else begin
      if (popNow) void'(sb.pop_front());
      if (accept) sb.push_back(e);
      expOvf = accept && (e.port == 3'd5) && (bus.in_sel != 3'd5);
    end
    #1;
  endtask

  // Drive one offered word for one cycle.
  task automatic offer(input logic [WIDTH-1:0] d, input logic [2:0] s);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sel   = s;
    applyStimulus();
  endtask

  // Stop offering and run until the model is empty (bounded).
  task automatic drain(input int maxCycles);
    bus.in_valid = 1'b0;
    for (int i = 0; i < maxCycles && sb.size() != 0; i++) applyStimulus();
    applyStimulus();
  endtask

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    errors = 0;
    checks = 0;
    expOvf = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = '0;
    bus.out_ready = 6'b111111;

    // Reset and single delivery
    applyStimulus();
    rst = 1'b0;
    offer(16'h1234, 3'd3);
    drain(10);

    // In-order routing to every port, back to back
    for (int k = 0; k < 6; k++) offer(16'hA000 + 16'(k), 3'(k));
    drain(12);

    // Backpressure and full: third word must be refused
    bus.out_ready = 6'b000000;
    offer(16'h0001, 3'd2);
    offer(16'h0002, 3'd4);
    offer(16'h0003, 3'd0);
    offer(16'h0003, 3'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 6'b000100;
    applyStimulus();
    bus.out_ready = 6'b000000;
    applyStimulus();
    bus.out_ready = 6'b111111;
    drain(10);

    // Head-of-line blocking: port 0 ready must not let 0x0020 overtake
    bus.out_ready = 6'b000001;
    offer(16'h0010, 3'd1);
    offer(16'h0020, 3'd0);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus();
    bus.out_ready = 6'b000011;
    drain(10);

    // Out-of-range select folds to port 5 and pulses overflow_sel once
    bus.out_ready = 6'b111111;
    offer(16'hBEEF, 3'd7);
    offer(16'hCAFE, 3'd5);
    offer(16'h5A5A, 3'd6);
    drain(10);

    // Reset mid-stream discards buffered words; inputs ignored on that edge
    bus.out_ready = 6'b000000;
    offer(16'h1111, 3'd0);
    offer(16'h2222, 3'd1);
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h3333;
    bus.in_sel    = 3'd7;
    bus.out_ready = 6'b111111;
    applyStimulus();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus();

    // Sustained random traffic with random sink readiness
    for (int i = 0; i < 60; i++) begin
      bus.out_ready = 6'($urandom_range(0, 63));
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 16'($urandom);
      bus.in_sel    = 3'($urandom_range(0, 7));
      applyStimulus();
    end
    bus.out_ready = 6'b111111;
    drain(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux6output.md
# demux6output

Six-way result distributor: accepts one 16-bit word plus a destination index over a valid/ready handshake, buffers it in a small FIFO, and delivers it to exactly one of six destination ports, each with its own valid/ready handshake. It is the fan-out counterpart of the six-input result mux on the datapath: the mux selects one of six sources onto a bus, and this block steers one bus value to one of six sinks (register write-back, memory, I/O) with backpressure.

## Interface
Parameters:
- WIDTH, 16, data width of input and delivered word
- DEPTH, 2, FIFO entries; a power of two, at least 2

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  word to distribute
- in_sel  input  3  destination index; 0..4 select ports 0..4, and 5, 6, 7 all select port 5
- in_valid  input  1  producer offers in_data/in_sel
- in_ready  output  1  block can accept; transfer occurs when in_valid && in_ready
- out_data  output  WIDTH  head-of-FIFO word, shared by all six ports
- out_valid  output  6  one-hot; bit k set when the head word is destined for port k
- out_ready  input  6  per-port sink ready
- busy  output  1  FIFO non-empty
- overflow_sel  output  1  one-cycle pulse when an accepted word had in_sel of 6 or 7

## Operation
- Storage is a DEPTH-entry FIFO of {data, port index}. in_sel is normalised to a 0..5 port index at push time.
- Push: in_valid && in_ready writes to the tail.
- Pop: the head is presented when the FIFO is non-empty. out_valid = onehot(head port). Pop when out_ready[head port] is high. out_ready bits of non-addressed ports are ignored.
- in_ready = (count < DEPTH). It does not depend on this cycle's pop, so there is no combinational ready path from out_ready to in_ready.
- Simultaneous push and pop with count between 1 and DEPTH-1: count is unchanged and pointers both advance.
- When count is 0, push only. The word becomes visible on the next cycle; there is no same-cycle bypass.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Words are delivered in strict acceptance order. A stalled port blocks all later words, including words for other ports (head-of-line blocking by design).
- out_data and out_valid remain stable while out_valid is set and the addressed out_ready is low.
- overflow_sel is registered and pulses on the cycle after the acceptance of a word with in_sel of 6 or 7. The word is still delivered to port 5.
- busy = (count != 0).

## Timing
- Reset (rst high at a clock edge): count, read pointer and write pointer go to 0, and overflow_sel goes to 0. After reset, out_valid = 0, busy = 0, in_ready = 1, and out_data = 0.
- FIFO memory need not be cleared. out_data is forced to 0 when the FIFO is empty.
- Latency: a word accepted at edge N is presented (out_valid set) after edge N and is poppable at edge N+1 at the earliest.
- Throughput: one word per cycle sustained when the addressed sinks hold ready high and DEPTH ≥ 2.
- Full condition: count = DEPTH forces in_ready = 0. A pop in that cycle frees a slot, and in_ready rises the following cycle.
- Reset mid-operation: all buffered words are discarded. No out_valid is asserted on the cycle after a reset edge.
- An edge with rst high ignores in_valid and out_ready on that edge.

## Test plan
- Reset and single delivery: apply reset, then push 0x1234 with sel=3 while all out_ready = 1. Required: in_ready = 1 after reset, then out_valid = 6'b001000 and out_data = 0x1234 the next cycle, busy then falls.
- In-order routing: push 0xA000+k with sel=k for k = 0..5, back to back, with all out_ready = 1. Required: six consecutive cycles with out_valid = 1<<k and out_data = 0xA000+k, and in_ready stays 1 throughout.
- Backpressure and full: hold out_ready = 0 and push 0x0001 (sel 2), 0x0002 (sel 4), then offer 0x0003. Required: in_ready = 0 after the second push, and 0x0003 is not accepted. Then raise out_ready[2]: 0x0001 pops, and the next cycle in_ready = 1.
- Head-of-line blocking: queue 0x0010 (sel 1) and 0x0020 (sel 0), with out_ready = 6'b000001. Required: out_valid stays 6'b000010 with data 0x0010 until out_ready[1] rises, and 0x0020 is never presented early.
- Out-of-range select: push 0xBEEF with sel=7, then 0xCAFE with sel=5. Required: both are delivered with out_valid = 6'b100000, and overflow_sel pulses for one cycle only after the first push.
- Reset mid-stream: fill the FIFO with out_ready = 0, then assert rst for one edge. Required: busy = 0, out_valid = 0 and in_ready = 1 the next cycle, and no buffered word appears afterward.
